// File: rtl/bb_pfd.sv
// Bang-bang phase/frequency detector: pairs ref/fb rising edges, reports
// which edge came first and by how many clk cycles, and tracks lock.
module bb_pfd #(
    parameter int unsigned WIN_W    = 6,
    parameter int unsigned TIMEOUT  = 40,
    parameter int unsigned LOCK_TH  = 2,
    parameter int unsigned LOCK_CNT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ref_in,
    input  logic             fb_in,
    output logic             early,
    output logic             early_vld,
    output logic [WIN_W-1:0] lead_cnt,
    output logic             locked,
    output logic             timeout_err
);

    localparam int unsigned LCW = 5;
    localparam logic [WIN_W-1:0] TIMEOUT_V  = WIN_W'(TIMEOUT);
    localparam logic [WIN_W-1:0] LOCK_TH_V  = WIN_W'(LOCK_TH);
    localparam logic [WIN_W-1:0] CNT_ONE    = WIN_W'(1);
    localparam logic [LCW-1:0]   LOCK_CNT_V = LCW'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FB,
        WAIT_REF
    } state_e;

    state_e           state_q, state_d;
    logic [WIN_W-1:0] cnt_q, cnt_d;
    logic             ref_q, fb_q;
    logic             early_q, early_d;
    logic             vld_q, vld_d;
    logic [WIN_W-1:0] lead_q, lead_d;
    logic             locked_q, locked_d;
    logic             terr_q, terr_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

    logic             ref_edge, fb_edge;
    logic             dec, dec_early;
    logic [WIN_W-1:0] dec_lead;

    assign ref_edge = ref_in & ~ref_q;
    assign fb_edge  = fb_in & ~fb_q;

    // State, measurement and output registers; edge history resets high
    // so a level already high at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ref_q      <= 1'b1;
            fb_q       <= 1'b1;
            early_q    <= 1'b0;
            vld_q      <= 1'b0;
            lead_q     <= '0;
            locked_q   <= 1'b0;
            terr_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_q      <= ref_in;
            fb_q       <= fb_in;
            early_q    <= early_d;
            vld_q      <= vld_d;
            lead_q     <= lead_d;
            locked_q   <= locked_d;
            terr_q     <= terr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Edge pairing, decision generation and lock tracking.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        early_d    = early_q;
        vld_d      = 1'b0;
        lead_d     = lead_q;
        terr_d     = 1'b0;
        lock_cnt_d = lock_cnt_q;
        dec        = 1'b0;
        dec_early  = 1'b0;
        dec_lead   = '0;

        case (state_q)
            IDLE: begin
                if (ref_edge && fb_edge) begin
                    // Tie: alternate the decision so the loop dithers around zero.
                    dec       = 1'b1;
                    dec_early = ~early_q;
                end else if (ref_edge) begin
                    state_d = WAIT_FB;
                    cnt_d   = CNT_ONE;
                end else if (fb_edge) begin
                    state_d = WAIT_REF;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_FB: begin
                if (fb_edge || ref_edge) begin
                    // fb closes the pair; a second ref edge is a cycle slip.
                    dec       = 1'b1;
                    dec_early = 1'b1;
                    dec_lead  = cnt_q;
                    if (ref_edge) begin
                        cnt_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == TIMEOUT_V) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_REF: begin
                if (ref_edge || fb_edge) begin
                    dec       = 1'b1;
                    dec_early = 1'b0;
                    dec_lead  = cnt_q;
                    if (fb_edge) begin
                        cnt_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == TIMEOUT_V) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (dec) begin
            vld_d   = 1'b1;
            early_d = dec_early;
            lead_d  = dec_lead;
            if (dec_lead <= LOCK_TH_V) begin
                lock_cnt_d = (lock_cnt_q == LOCK_CNT_V) ? lock_cnt_q : lock_cnt_q + LCW'(1);
            end else begin
                lock_cnt_d = '0;
            end
        end
        if (terr_d) begin
            lock_cnt_d = '0;
        end
        locked_d = (lock_cnt_d == LOCK_CNT_V);
    end

    assign early       = early_q;
    assign early_vld   = vld_q;
    assign lead_cnt    = lead_q;
    assign locked      = locked_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_bb_pfd.sv
// Randomized and directed bench for bb_pfd against a timestamp-based model.
module tb_bb_pfd;

    localparam int unsigned WIN_W    = 6;
    localparam int unsigned TIMEOUT  = 40;
    localparam int unsigned LOCK_TH  = 2;
    localparam int unsigned LOCK_CNT = 16;

    logic             clk;
    logic             reset;
    logic             ref_in;
    logic             fb_in;
    logic             early;
    logic             early_vld;
    logic [WIN_W-1:0] lead_cnt;
    logic             locked;
    logic             timeout_err;

    bb_pfd #(
        .WIN_W   (WIN_W),
        .TIMEOUT (TIMEOUT),
        .LOCK_TH (LOCK_TH),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ref_in     (ref_in),
        .fb_in      (fb_in),
        .early      (early),
        .early_vld  (early_vld),
        .lead_cnt   (lead_cnt),
        .locked     (locked),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: remembers which side opened a measurement and when.
    int m_pend;    // 0 none, 1 ref seen (waiting fb), 2 fb seen (waiting ref)
    int m_topen;
    int m_now;
    int m_pr, m_pf;
    int m_early, m_lead, m_vld, m_terr, m_locked, m_streak;

    int obs_vld, obs_terr;
    logic rr, ff;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_topen = 0; m_now = 0;
        m_pr = 1; m_pf = 1;
        m_early = 0; m_lead = 0; m_vld = 0; m_terr = 0; m_locked = 0; m_streak = 0;
    endtask

    task automatic model_step(input int r, input int f);
        int re, fe, decide, e, l;
        re = (r == 1 && m_pr == 0) ? 1 : 0;
        fe = (f == 1 && m_pf == 0) ? 1 : 0;
        m_pr = r; m_pf = f;
        m_now++;
        m_vld = 0; m_terr = 0; decide = 0; e = 0; l = 0;
        if (m_pend == 0) begin
            if (re == 1 && fe == 1) begin
                decide = 1; e = 1 - m_early; l = 0;
            end else if (re == 1) begin
                m_pend = 1; m_topen = m_now;
            end else if (fe == 1) begin
                m_pend = 2; m_topen = m_now;
            end
        end else begin
            int close, slip;
            close = (m_pend == 1) ? fe : re;
            slip  = (m_pend == 1) ? re : fe;
            if (close == 1 || slip == 1) begin
                decide = 1; e = (m_pend == 1) ? 1 : 0; l = m_now - m_topen;
                if (slip == 1) m_topen = m_now;
                else m_pend = 0;
            end else if (m_now - m_topen == int'(TIMEOUT)) begin
                m_terr = 1; m_pend = 0;
            end
        end
        if (decide == 1) begin
            m_vld = 1; m_early = e; m_lead = l;
            if (l <= int'(LOCK_TH)) m_streak = (m_streak + 1 > int'(LOCK_CNT)) ? int'(LOCK_CNT) : m_streak + 1;
            else m_streak = 0;
        end
        if (m_terr == 1) m_streak = 0;
        m_locked = (m_streak >= int'(LOCK_CNT)) ? 1 : 0;
    endtask

    // One clk cycle: drive levels, advance model, compare after the edge.
    task automatic cyc(input logic r, input logic f);
        ref_in = r;
        fb_in  = f;
        model_step(int'(r), int'(f));
        @(posedge clk);
        @(negedge clk);
        chk("early", int'(early), m_early);
        chk("early_vld", int'(early_vld), m_vld);
        chk("lead_cnt", int'(lead_cnt), m_lead);
        chk("locked", int'(locked), m_locked);
        chk("timeout_err", int'(timeout_err), m_terr);
        obs_vld  += int'(early_vld);
        obs_terr += int'(timeout_err);
    endtask

    // Asynchronous reset pulse; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_early", int'(early), 0);
        chk("rst_vld", int'(early_vld), 0);
        chk("rst_lead", int'(lead_cnt), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_terr", int'(timeout_err), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic lead_pair(input int lead);
        cyc(1'b1, 1'b0);
        for (int i = 1; i < lead; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        int tie_exp[3];
        int mode, off;
        tie_exp = '{1, 0, 1};
        reset = 1'b0;
        ref_in = 1'b0;
        fb_in = 1'b0;
        rr = 1'b0;
        ff = 1'b0;
        obs_vld = 0;
        obs_terr = 0;
        model_reset();
        #1;
        chk("por_vld", int'(early_vld), 0);
        chk("por_locked", int'(locked), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Ties from reset dither the decision 1,0,1 with zero lead.
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            chk("tie_vld", int'(early_vld), 1);
            chk("tie_early", int'(early), tie_exp[i]);
            chk("tie_lead", int'(lead_cnt), 0);
            chk("tie_locked", int'(locked), 0);
            cyc(1'b0, 1'b0);
        end

        // ref leads fb by 3 cycles.
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("ref_lead_vld", int'(early_vld), 1);
        chk("ref_lead_early", int'(early), 1);
        chk("ref_lead_cnt", int'(lead_cnt), 3);
        cyc(1'b0, 1'b0);
        chk("hold_lead", int'(lead_cnt), 3);

        // fb leads ref by 5 cycles.
        repeat (5) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("fb_lead_early", int'(early), 0);
        chk("fb_lead_cnt", int'(lead_cnt), 5);
        cyc(1'b0, 1'b0);

        // Lock acquisition, then loss by timeout.
        do_reset();
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) lead_pair(1);
        chk("lock_15", int'(locked), 0);
        lead_pair(1);
        chk("lock_16", int'(locked), 1);
        obs_vld = 0;
        obs_terr = 0;
        cyc(1'b1, 1'b0);
        repeat (44) cyc(1'b1, 1'b0);
        chk("timeout_pulses", obs_terr, 1);
        chk("timeout_no_vld", obs_vld, 0);
        chk("timeout_unlock", int'(locked), 0);
        cyc(1'b0, 1'b0);

        // Relock, then a wide pair drops lock in its own update cycle.
        for (int i = 0; i < 16; i++) lead_pair(1);
        chk("relock", int'(locked), 1);
        repeat (5) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("wide_lead", int'(lead_cnt), 5);
        chk("wide_unlock", int'(locked), 0);
        cyc(1'b0, 1'b0);

        // Reset during WAIT_FB with ref held high: no edge, no strobes.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        do_reset();
        obs_vld = 0;
        obs_terr = 0;
        repeat (50) cyc(1'b1, 1'b0);
        chk("held_no_vld", obs_vld, 0);
        chk("held_no_terr", obs_terr, 0);
        chk("held_early", int'(early), 0);
        chk("held_lead", int'(lead_cnt), 0);

        // Randomized blocks with varied edge densities and periodic pairs.
        rr = 1'b1;
        ff = 1'b0;
        for (int b = 0; b < 16; b++) begin
            mode = int'($urandom_range(0, 3));
            off  = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) do_reset();
            for (int t = 0; t < 200; t++) begin
                case (mode)
                    0: begin
                        if ($urandom_range(0, 1) == 0) rr = ~rr;
                        if ($urandom_range(0, 1) == 0) ff = ~ff;
                    end
                    1: begin
                        if ($urandom_range(0, 3) == 0) rr = ~rr;
                        if ($urandom_range(0, 3) == 0) ff = ~ff;
                    end
                    2: begin
                        if ($urandom_range(0, 31) == 0) rr = ~rr;
                        if ($urandom_range(0, 47) == 0) ff = ~ff;
                    end
                    default: begin
                        rr = ((t % 8) < 4);
                        ff = (((t + 8 - off) % 8) < 4);
                    end
                endcase
                cyc(rr, ff);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bb_pfd.md
BB_PFD -- requirements
Module: bb_pfd

Interface
REQ-001 Parameter WIN_W, default 6; width of the phase-error counter and the lead_cnt output.
REQ-002 Parameter TIMEOUT, default 40; maximum cycles to wait for the partner edge; SHALL satisfy 2 <= TIMEOUT <= 2^WIN_W-1.
REQ-003 Parameter LOCK_TH, default 2; largest lead_cnt counted as "in lock".
REQ-004 Parameter LOCK_CNT, default 16; consecutive in-lock decisions required to assert locked; 5-bit internal counter.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ref_in  input  1  reference clock level, already synchronous to clk.
REQ-008 fb_in  input  1  divided DCO feedback level, already synchronous to clk.
REQ-009 early  output  1  decision: 1 = ref edge preceded fb edge (DCO slow), 0 = fb preceded ref; feeds the loop-filter integral/proportional paths.
REQ-010 early_vld  output  1  one-cycle strobe marking a new decision on early and lead_cnt.
REQ-011 lead_cnt  output  WIN_W  magnitude in clk cycles between the paired edges.
REQ-012 locked  output  1  lock indicator.
REQ-013 timeout_err  output  1  one-cycle strobe: partner edge missing.

Function
REQ-014 Rising edges SHALL be detected as in=1 and registered previous sample=0; previous-sample registers hold 1 after reset, so an input already high at reset release is not an edge.
REQ-015 FSM states SHALL be IDLE, WAIT_FB, WAIT_REF.
REQ-016 IDLE, ref edge only -> WAIT_FB, counter=1; fb edge only -> WAIT_REF, counter=1; neither -> stay IDLE.
REQ-017 IDLE, ref and fb edges same cycle -> stay IDLE; decision with lead_cnt=0 and early = inverse of current early (tie dither).
REQ-018 WAIT_FB, fb edge -> decision early=1, lead_cnt=counter; next state IDLE, or WAIT_FB with counter=1 if a ref edge arrives in the same cycle.
REQ-019 WAIT_FB, second ref edge without fb edge (cycle slip) -> decision early=1, lead_cnt=counter; stay WAIT_FB, counter=1.
REQ-020 WAIT_REF SHALL mirror REQ-018/019 with ref/fb swapped and early=0.
REQ-021 In WAIT states with no edge, counter SHALL increment by 1; when counter equals TIMEOUT with no closing edge: timeout_err pulse, no decision, next state IDLE.
REQ-022 All outputs SHALL be registered; early, lead_cnt and early_vld update in the cycle after the closing edge is sampled (latency 1); early and lead_cnt hold between decisions.
REQ-023 Each decision with lead_cnt <= LOCK_TH SHALL increment the lock counter (saturating at LOCK_CNT); locked SHALL assert when it reaches LOCK_CNT.
REQ-024 A decision with lead_cnt > LOCK_TH, or any timeout, SHALL clear the lock counter and deassert locked in the same update cycle.
REQ-025 Ties (REQ-017) SHALL count as in-lock decisions.

Reset
REQ-026 reset low SHALL immediately force: state IDLE, counter 0, early 0, early_vld 0, lead_cnt 0, locked 0, timeout_err 0, lock counter 0, edge registers 1.
REQ-027 Reset asserted mid-WAIT SHALL discard the pending measurement; no decision or timeout strobe after release until a new edge pair.

Verification
REQ-028 ref rises cycle 10, fb rises cycle 13 -> early_vld pulse cycle 14 with early=1, lead_cnt=3; state IDLE.
REQ-029 fb rises cycle 10, ref rises cycle 15 -> early_vld cycle 16 with early=0, lead_cnt=5.
REQ-030 ref and fb rise together three times from reset -> early sequence 1,0,1 with lead_cnt=0; locked stays 0.
REQ-031 ref rises, fb absent for 40 cycles -> timeout_err single pulse, no early_vld, locked forced 0.
REQ-032 16 consecutive pairs with 1-cycle ref lead -> locked=1 after 16th decision; one pair with 5-cycle lead -> locked=0 in that update cycle.
REQ-033 ref_in held high through reset release, reset pulsed low during WAIT_FB -> no edge detected, no strobes, all outputs 0 until next genuine edge pair.
